// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, external hold and leap squash.
// Instruction bit 0 is the MSB; rs1/rs2 are taken from the registered decode-side word.
module if_id_stage #(
  parameter logic [0:31] NOP_INSTR = 32'h54000000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:31]      if_pcplus4,
  input  logic [0:31]      if_instruction,
  input  logic             leap,
  input  logic             ext_stall,
  input  logic             ex_mem_read,
  input  logic [0:4]       ex_rd,
  output logic [0:31]      id_pcplus4,
  output logic [0:31]      id_instruction,
  output logic             id_valid,
  output logic             pc_write_enable,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {RUN, LU_STALL, EXT_HOLD} state_t;

  state_t             state_q, state_d;
  logic [0:31]        pc_q, pc_d;
  logic [0:31]        instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [0:4]         rs1, rs2;
  logic               hazard;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign rs1 = instr_q[6:10];
  assign rs2 = instr_q[11:15];

  // Hazard is only evaluated in RUN so a stalled load is never bubbled twice.
  assign hazard = (state_q == RUN) && valid_q && ex_mem_read && (ex_rd != 5'd0) &&
                  ((ex_rd == rs1) || (ex_rd == rs2));

  assign pc_write_enable = !(hazard || ext_stall) || leap;
  assign id_ex_bubble    = hazard && !leap;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (hazard && !leap)         state_d = LU_STALL;
        else if (ext_stall && !leap) state_d = EXT_HOLD;
      end
      LU_STALL: state_d = ext_stall ? EXT_HOLD : RUN;
      EXT_HOLD: state_d = ext_stall ? EXT_HOLD : RUN;
      default:  state_d = RUN;
    endcase
  end

  // Flush beats any stall; the leap target PC+4 is captured the same edge.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    cnt_d   = pc_write_enable ? cnt_q : sat_inc(cnt_q);
    if (leap) begin
      pc_d    = if_pcplus4;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!(hazard || ext_stall)) begin
      pc_d    = if_pcplus4;
      instr_d = if_instruction;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign id_pcplus4     = pc_q;
  assign id_instruction = instr_q;
  assign id_valid       = valid_q;
  assign stall_count    = cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: each driven cycle queues the hand-computed
// outputs expected in that cycle; a negedge monitor pops and compares them.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h54000000;
  localparam logic [31:0] I1  = 32'h20220005; // rs1=1 rs2=2
  localparam logic [31:0] I2  = 32'h00A90000; // rs1=5 rs2=9
  localparam logic [31:0] I3  = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:31] if_pcplus4, if_instruction;
  logic        leap, ext_stall, ex_mem_read;
  logic [0:4]  ex_rd;
  logic [0:31] id_pcplus4, id_instruction;
  logic        id_valid, pc_write_enable, id_ex_bubble;
  logic [15:0] stall_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        v;
    logic        we;
    logic        bub;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  if_id_stage #(.NOP_INSTR(32'h54000000), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .if_pcplus4(if_pcplus4), .if_instruction(if_instruction),
    .leap(leap), .ext_stall(ext_stall), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .id_pcplus4(id_pcplus4), .id_instruction(id_instruction), .id_valid(id_valid),
    .pc_write_enable(pc_write_enable), .id_ex_bubble(id_ex_bubble), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("id_pcplus4",      id_pcplus4,      e.pc);
      cmp("id_instruction",  id_instruction,  e.ins);
      cmp("id_valid",        {31'd0, id_valid},        {31'd0, e.v});
      cmp("pc_write_enable", {31'd0, pc_write_enable}, {31'd0, e.we});
      cmp("id_ex_bubble",    {31'd0, id_ex_bubble},    {31'd0, e.bub});
      cmp("stall_count",     {16'd0, stall_count},     {16'd0, e.cnt});
    end
  end

  task automatic step(input logic rst, input logic [31:0] pc, input logic [31:0] ins,
                      input logic lp, input logic ext, input logic mr, input logic [4:0] rd,
                      input logic [31:0] e_pc, input logic [31:0] e_ins, input logic e_v,
                      input logic e_we, input logic e_bub, input logic [15:0] e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; if_pcplus4 = pc; if_instruction = ins;
    leap = lp; ext_stall = ext; ex_mem_read = mr; ex_rd = rd;
    e.pc = e_pc; e.ins = e_ins; e.v = e_v; e.we = e_we; e.bub = e_bub; e.cnt = e_cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; if_pcplus4 = '0; if_instruction = '0;
    leap = 1'b0; ext_stall = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
    // reset, second cycle observed
    step(1, 0,  0,  0,0,0,0,  0,  NOP,1'b0,1,0,16'd0);
    // streaming
    step(0, 4,  I1, 0,0,0,0,  0,  NOP,1'b0,1,0,16'd0);
    step(0, 8,  I1, 0,0,0,0,  4,  I1, 1'b1,1,0,16'd0);
    step(0, 12, I1, 0,0,0,0,  8,  I1, 1'b1,1,0,16'd0);
    step(0, 16, I2, 0,0,0,0,  12, I1, 1'b1,1,0,16'd0);
    // load-use on rs1
    step(0, 20, I3, 0,0,1,5,  16, I2, 1'b1,0,1,16'd0);
    step(0, 20, I3, 0,0,0,0,  16, I2, 1'b1,1,0,16'd1);
    step(0, 24, I1, 0,0,0,0,  20, I3, 1'b1,1,0,16'd1);
    step(0, 28, I2, 0,0,0,0,  24, I1, 1'b1,1,0,16'd1);
    // ex_rd=0 and non-matching rd
    step(0, 32, I2, 0,0,1,0,  28, I2, 1'b1,1,0,16'd1);
    step(0, 36, I2, 0,0,1,7,  32, I2, 1'b1,1,0,16'd1);
    // hazard on rs2 coinciding with leap
    step(0, 40, I1, 1,0,1,9,  36, I2, 1'b1,1,0,16'd1);
    step(0, 44, I1, 0,0,0,0,  40, NOP,1'b0,1,0,16'd1);
    // load-use on rs2
    step(0, 48, I2, 0,0,1,2,  44, I1, 1'b1,0,1,16'd1);
    step(0, 48, I2, 0,0,0,0,  44, I1, 1'b1,1,0,16'd2);
    // hazard together with ext_stall: one bubble, then hold
    step(0, 52, I1, 0,1,1,5,  48, I2, 1'b1,0,1,16'd2);
    step(0, 52, I1, 0,1,0,0,  48, I2, 1'b1,0,0,16'd3);
    step(0, 52, I1, 0,0,0,0,  48, I2, 1'b1,1,0,16'd4);
    // long external hold, counter saturation
    for (int k = 0; k < 70000; k++) begin
      int c;
      c = (4 + k > 65535) ? 65535 : 4 + k;
      step(0, 56, I1, 0,1,0,0, 52, I1, 1'b1,0,0,c[15:0]);
    end
    step(0, 56, I1, 0,0,0,0,  52, I1, 1'b1,1,0,16'hFFFF);
    step(0, 60, I1, 0,0,0,0,  56, I1, 1'b1,1,0,16'hFFFF);
    // reset after saturation
    step(1, 64, I1, 0,0,0,0,  60, I1, 1'b1,1,0,16'hFFFF);
    step(0, 64, I1, 0,0,0,0,  0,  NOP,1'b0,1,0,16'd0);
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
